branch_cond_serial_r32i: RTL and testbench

- Multi-cycle, parametrised successor to the single-cycle RV32I branch condition generator.
- Accepts rs1/rs2 plus the branch funct3 over a valid/ready handshake, and compares operands CHUNKW bits per cycle, most significant chunk first.
- Returns EQ/LT/LTU flags, a resolved taken bit and an illegal-encoding flag over a second valid/ready handshake.
- Used in area-reduced cores where the branch resolution path is sequenced by the execute stage.

---
 rtl/branch_cond_serial_r32i.sv | 145 ++++++++++++++
 tb/tb_branch_cond_serial_r32i.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/branch_cond_serial_r32i.sv
// Serial RV32I branch condition unit: compares operands CHUNKW bits per cycle, MSB chunk first.
// Define COND_EARLY_EXIT_EN to finish on the first differing chunk instead of always scanning all chunks.
module branch_cond_serial_r32i #(
    parameter int dataW  = 32,
    parameter int CHUNKW = 8
) (
    input  logic             clk,
    input  logic             nReset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [dataW-1:0] rs1,
    input  logic [dataW-1:0] rs2,
    input  logic [2:0]       funct3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             taken,
    output logic             EQ,
    output logic             LT,
    output logic             LTU,
    output logic             illegal
);

    localparam int N    = dataW / CHUNKW;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [IDXW-1:0]   TOPIDX  = IDXW'(N - 1);
    localparam logic [CHUNKW-1:0] MSBMASK = CHUNKW'(1) << (CHUNKW - 1);

    typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;

    state_t            state, nextState;
    logic [dataW-1:0]  opA, opB;
    logic [2:0]        f3Reg;
    logic [IDXW-1:0]   idx;
    logic              resolved, eqInt, ltInt, ltuInt;
    logic [CHUNKW-1:0] chunkA, chunkB, sA, sB;
    logic              isTop, diff, chunkLt, chunkLtu, exitNow;
    logic              fEq, fLt, fLtu, fTaken;

    // Only the top chunk carries the sign; flipping its MSB turns a signed compare into an unsigned one.
    always_comb begin
        chunkA   = opA[idx*CHUNKW +: CHUNKW];
        chunkB   = opB[idx*CHUNKW +: CHUNKW];
        isTop    = (idx == TOPIDX);
        sA       = isTop ? (chunkA ^ MSBMASK) : chunkA;
        sB       = isTop ? (chunkB ^ MSBMASK) : chunkB;
        diff     = (chunkA != chunkB);
        chunkLtu = (chunkA < chunkB);
        chunkLt  = (sA < sB);
`ifdef COND_EARLY_EXIT_EN
        exitNow  = (idx == '0) || (diff && !resolved);
`else
        exitNow  = (idx == '0);
`endif
        fEq  = 1'b1;
        fLt  = 1'b0;
        fLtu = 1'b0;
        if (resolved) begin
            fEq  = eqInt;
            fLt  = ltInt;
            fLtu = ltuInt;
        end else if (diff) begin
            fEq  = 1'b0;
            fLt  = chunkLt;
            fLtu = chunkLtu;
        end
        case (f3Reg)
            3'b000:  fTaken = fEq;
            3'b001:  fTaken = !fEq;
            3'b100:  fTaken = fLt;
            3'b101:  fTaken = !fLt;
            3'b110:  fTaken = fLtu;
            3'b111:  fTaken = !fLtu;
            default: fTaken = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) state <= IDLE;
        else         state <= nextState;
    end

    always_comb begin
        nextState = state;
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (in_valid) nextState = COMPARE;
            COMPARE: if (exitNow) nextState = DONE;
            DONE:    if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (flush) nextState = IDLE;
    end

    // Outputs only change on the COMPARE->DONE transition, so they stay put outside DONE.
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            opA      <= '0;
            opB      <= '0;
            f3Reg    <= '0;
            idx      <= TOPIDX;
            resolved <= 1'b0;
            eqInt    <= 1'b0;
            ltInt    <= 1'b0;
            ltuInt   <= 1'b0;
            EQ       <= 1'b0;
            LT       <= 1'b0;
            LTU      <= 1'b0;
            taken    <= 1'b0;
            illegal  <= 1'b0;
        end else if (!flush) begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        opA      <= rs1;
                        opB      <= rs2;
                        f3Reg    <= funct3;
                        idx      <= TOPIDX;
                        resolved <= 1'b0;
                    end
                end
                COMPARE: begin
                    if (diff && !resolved) begin
                        resolved <= 1'b1;
                        eqInt    <= 1'b0;
                        ltInt    <= chunkLt;
                        ltuInt   <= chunkLtu;
                    end
                    if (exitNow) begin
                        EQ      <= fEq;
                        LT      <= fLt;
                        LTU     <= fLtu;
                        taken   <= fTaken;
                        illegal <= (f3Reg[2:1] == 2'b01);
                    end else begin
                        idx <= idx - IDXW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_cond_serial_r32i.sv
// Bench for branch_cond_serial_r32i: directed table, random ops against a reference model, handshake corners.
// Expected latency follows COND_EARLY_EXIT_EN when the same define is passed to the bench.
module tb_branch_cond_serial_r32i;

    localparam int N = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        taken;
        logic        eq;
        logic        lt;
        logic        ltu;
        logic        ill;
        int          latEn;
        int          latNo;
    } vec_t;

    logic        clk = 1'b0;
    logic        nReset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1, rs2;
    logic [2:0]  funct3;
    logic        out_valid;
    logic        out_ready;
    logic        taken, EQ, LT, LTU, illegal;

    int checks = 0;
    int passed = 0;

    branch_cond_serial_r32i #(.dataW(32), .CHUNKW(8)) dut (
        .clk(clk), .nReset(nReset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .funct3(funct3),
        .out_valid(out_valid), .out_ready(out_ready),
        .taken(taken), .EQ(EQ), .LT(LT), .LTU(LTU), .illegal(illegal)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [2:0] f3,
                                logic tk, logic eq, logic lt, logic ltu, logic ill,
                                int le, int ln);
        vec_t v;
        v.a = a; v.b = b; v.f3 = f3;
        v.taken = tk; v.eq = eq; v.lt = lt; v.ltu = ltu; v.ill = ill;
        v.latEn = le; v.latNo = ln;
        return v;
    endfunction

    // Reference: plain signed/unsigned arithmetic, latency from the first differing byte.
    function automatic vec_t model(logic [31:0] a, logic [31:0] b, logic [2:0] f3);
        vec_t m;
        bit found;
        m.a = a; m.b = b; m.f3 = f3;
        m.eq  = (a == b);
        m.lt  = ($signed(a) < $signed(b));
        m.ltu = (a < b);
        m.ill = (f3 == 3'b010) || (f3 == 3'b011);
        case (f3)
            3'b000:  m.taken = m.eq;
            3'b001:  m.taken = !m.eq;
            3'b100:  m.taken = m.lt;
            3'b101:  m.taken = !m.lt;
            3'b110:  m.taken = m.ltu;
            3'b111:  m.taken = !m.ltu;
            default: m.taken = 1'b0;
        endcase
        m.latNo = N;
        m.latEn = N;
        found = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (!found && (a[i*8 +: 8] != b[i*8 +: 8])) begin
                m.latEn = N - i;
                found = 1;
            end
        end
        return m;
    endfunction

    task automatic checkValue(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp)
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic applyStimulus(logic [31:0] a, logic [31:0] b, logic [2:0] f3, output int lat);
        int w = 0;
        rs1 = a; rs2 = b; funct3 = f3; in_valid = 1'b1;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        checkValue("accept_in_time", 32'(w < 20), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic checkOutput(string name, vec_t e, int lat);
        int expLat;
`ifdef COND_EARLY_EXIT_EN
        expLat = e.latEn;
`else
        expLat = e.latNo;
`endif
        checkValue({name, ".out_valid"}, 32'(out_valid), 32'd1);
        checkValue({name, ".taken"},     32'(taken),     32'(e.taken));
        checkValue({name, ".EQ"},        32'(EQ),        32'(e.eq));
        checkValue({name, ".LT"},        32'(LT),        32'(e.lt));
        checkValue({name, ".LTU"},       32'(LTU),       32'(e.ltu));
        checkValue({name, ".illegal"},   32'(illegal),   32'(e.ill));
        checkValue({name, ".latency"},   32'(lat),       32'(expLat));
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkValue({name, ".in_ready_after"}, 32'(in_ready), 32'd1);
        checkValue({name, ".out_valid_after"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        vec_t tbl[11];
        vec_t m;
        int   lat;
        logic [31:0] a, b;
        bit   sawValid;

        tbl[0]  = mk(32'h80000000, 32'h00000001, 3'b100, 1, 0, 1, 0, 0, 1, 4);
        tbl[1]  = mk(32'h80000000, 32'h00000001, 3'b110, 0, 0, 1, 0, 0, 1, 4);
        tbl[2]  = mk(32'h80000000, 32'h00000001, 3'b111, 1, 0, 1, 0, 0, 1, 4);
        tbl[3]  = mk(32'h12345678, 32'h12345678, 3'b000, 1, 1, 0, 0, 0, 4, 4);
        tbl[4]  = mk(32'h12345678, 32'h12345678, 3'b001, 0, 1, 0, 0, 0, 4, 4);
        tbl[5]  = mk(32'h12345679, 32'h12345678, 3'b101, 1, 0, 0, 0, 0, 4, 4);
        tbl[6]  = mk(32'hFFFFFFFF, 32'h00000000, 3'b100, 1, 0, 1, 0, 0, 1, 4);
        tbl[7]  = mk(32'hFFFFFFFF, 32'h00000000, 3'b110, 0, 0, 1, 0, 0, 1, 4);
        tbl[8]  = mk(32'h00000100, 32'h00000200, 3'b010, 0, 0, 1, 1, 1, 3, 4);
        tbl[9]  = mk(32'h00000000, 32'h00000000, 3'b011, 0, 1, 0, 0, 1, 4, 4);
        tbl[10] = mk(32'h7FFFFFFF, 32'h80000000, 3'b101, 1, 0, 0, 1, 0, 1, 4);

        nReset = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        rs1 = '0; rs2 = '0; funct3 = '0;
        #1;
        checkValue("reset.out_valid", 32'(out_valid), 32'd0);
        checkValue("reset.in_ready",  32'(in_ready),  32'd1);
        checkValue("reset.flags", 32'({taken, EQ, LT, LTU, illegal}), 32'd0);
        #12 nReset = 1'b1;

        $display("[TB] directed table");
        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].a, tbl[i].b, tbl[i].f3, lat);
            checkOutput($sformatf("vec%0d", i), tbl[i], lat);
        end

        $display("[TB] random ops against reference model");
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 2))
                0:       b = $urandom;
                1:       b = a;
                default: begin
                    b = a;
                    b[$urandom_range(0, 3)*8 +: 8] = 8'($urandom);
                end
            endcase
            m = model(a, b, 3'($urandom_range(0, 7)));
            applyStimulus(m.a, m.b, m.f3, lat);
            checkOutput($sformatf("rand%0d", i), m, lat);
        end

        $display("[TB] backpressure hold in DONE");
        applyStimulus(tbl[0].a, tbl[0].b, tbl[0].f3, lat);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checkValue("hold.out_valid", 32'(out_valid), 32'd1);
            checkValue("hold.in_ready",  32'(in_ready),  32'd0);
            checkValue("hold.flags", 32'({taken, EQ, LT, LTU, illegal}), 32'b10100);
        end
        checkOutput("hold", tbl[0], lat - 3 + 3);

        $display("[TB] flush during COMPARE");
        rs1 = 32'h12345678; rs2 = 32'h12345678; funct3 = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        checkValue("flush.accepted", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkValue("flush.in_ready", 32'(in_ready), 32'd1);
        checkValue("flush.out_valid", 32'(out_valid), 32'd0);
        in_valid = 1'b0;
        sawValid = 0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (out_valid) sawValid = 1;
        end
        checkValue("flush.no_result", 32'(sawValid), 32'd0);

        $display("[TB] async reset during COMPARE");
        applyStimulus(tbl[6].a, tbl[6].b, tbl[6].f3, lat);
        checkOutput("pre_reset", tbl[6], lat);
        rs1 = 32'h12345678; rs2 = 32'h12345678; funct3 = 3'b000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #2;
        nReset = 1'b0;
        #1;
        checkValue("arst.out_valid", 32'(out_valid), 32'd0);
        checkValue("arst.flags", 32'({taken, EQ, LT, LTU, illegal}), 32'd0);
        checkValue("arst.in_ready", 32'(in_ready), 32'd1);
        nReset = 1'b1;
        applyStimulus(tbl[5].a, tbl[5].b, tbl[5].f3, lat);
        checkOutput("post_reset", tbl[5], lat);

        $display("[TB] %0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
